// File: rtl/dtm_jtag.sv
// rtl/dtm_jtag.sv - JTAG debug transport module with clk-sampled TAP and DMI request/finish handshake
module dtm_jtag #(
  parameter logic [31:0] IDCODE = 32'h1BEEF001
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tck,
  input  logic         tms,
  input  logic         tdi,
  output logic         tdo,
  output logic         dmi_start,
  input  logic         dmi_finish,
  output logic [1:0]   dmi_op,
  output logic [33:2]  dmi_data_o,
  input  logic [33:2]  dmi_data_i,
  output logic [40:34] dmi_address
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [1:0] OP_READ   = 2'd1;
  localparam logic [1:0] OP_WRITE  = 2'd2;

  tap_e        state_q, state_d, tap_next;
  logic        tck_s1_q, tck_s1_d, tck_s2_q, tck_s2_d, tck_prev_q, tck_prev_d;
  logic        tms_s1_q, tms_s1_d, tms_s2_q, tms_s2_d;
  logic        tdi_s1_q, tdi_s1_d, tdi_s2_q, tdi_s2_d;
  logic        rise_q, rise_d, fall_q, fall_d;
  logic [4:0]  ir_q, ir_d;
  logic [40:0] sr_q, sr_d;
  logic        tdo_q, tdo_d;
  logic        busy_q, busy_d;
  logic [1:0]  sticky_q, sticky_d;
  logic [31:0] result_q, result_d;
  logic        dmi_start_q, dmi_start_d;
  logic [1:0]  dmi_op_q, dmi_op_d;
  logic [31:0] dmi_data_q, dmi_data_d;
  logic [6:0]  dmi_addr_q, dmi_addr_d;
  logic [5:0]  dr_msb;
  logic [1:0]  dmi_status;

  // TAP next state from the synced tms, used when a rise has been seen
  always_comb begin
    tap_next = state_q;
    case (state_q)
      TLR:     tap_next = tms_s2_q ? TLR    : RTI;
      RTI:     tap_next = tms_s2_q ? SEL_DR : RTI;
      SEL_DR:  tap_next = tms_s2_q ? SEL_IR : CAP_DR;
      CAP_DR:  tap_next = tms_s2_q ? EX1_DR : SH_DR;
      SH_DR:   tap_next = tms_s2_q ? EX1_DR : SH_DR;
      EX1_DR:  tap_next = tms_s2_q ? UPD_DR : PAU_DR;
      PAU_DR:  tap_next = tms_s2_q ? EX2_DR : PAU_DR;
      EX2_DR:  tap_next = tms_s2_q ? UPD_DR : SH_DR;
      UPD_DR:  tap_next = tms_s2_q ? SEL_DR : RTI;
      SEL_IR:  tap_next = tms_s2_q ? TLR    : CAP_IR;
      CAP_IR:  tap_next = tms_s2_q ? EX1_IR : SH_IR;
      SH_IR:   tap_next = tms_s2_q ? EX1_IR : SH_IR;
      EX1_IR:  tap_next = tms_s2_q ? UPD_IR : PAU_IR;
      PAU_IR:  tap_next = tms_s2_q ? EX2_IR : PAU_IR;
      EX2_IR:  tap_next = tms_s2_q ? UPD_IR : SH_IR;
      UPD_IR:  tap_next = tms_s2_q ? SEL_DR : RTI;
      default: tap_next = TLR;
    endcase
  end

  // Synchronizers, edge detect, shift/capture/update and the DMI handshake
  always_comb begin
    tck_s1_d    = tck;
    tck_s2_d    = tck_s1_q;
    tck_prev_d  = tck_s2_q;
    tms_s1_d    = tms;
    tms_s2_d    = tms_s1_q;
    tdi_s1_d    = tdi;
    tdi_s2_d    = tdi_s1_q;
    rise_d      = tck_s2_q & ~tck_prev_q;
    fall_d      = ~tck_s2_q & tck_prev_q;
    state_d     = state_q;
    ir_d        = ir_q;
    sr_d        = sr_q;
    tdo_d       = tdo_q;
    busy_d      = busy_q;
    sticky_d    = sticky_q;
    result_d    = result_q;
    dmi_start_d = 1'b0;
    dmi_op_d    = dmi_op_q;
    dmi_data_d  = dmi_data_q;
    dmi_addr_d  = dmi_addr_q;
    dmi_status  = busy_q ? 2'd3 : sticky_q;

    case (ir_q)
      IR_IDCODE, IR_DTMCS: dr_msb = 6'd31;
      IR_DMI:              dr_msb = 6'd40;
      default:             dr_msb = 6'd0;
    endcase

    // Completion from the debug module; an aborted or unexpected finish is dropped
    if (dmi_finish && busy_q) begin
      busy_d = 1'b0;
      if (dmi_op_q == OP_READ) result_d = dmi_data_i;
    end

    if (rise_q) begin
      state_d = tap_next;
      case (state_q)
        CAP_IR: sr_d = 41'd1;
        SH_IR: begin
          sr_d    = sr_q >> 1;
          sr_d[4] = tdi_s2_q;
        end
        CAP_DR: begin
          case (ir_q)
            IR_IDCODE: sr_d = {9'd0, IDCODE};
            IR_DTMCS:  sr_d = {9'd0, 20'h00001, sticky_q, 10'h071};
            IR_DMI:    sr_d = {dmi_addr_q, result_q, dmi_status};
            default:   sr_d = 41'd0;
          endcase
        end
        SH_DR: begin
          sr_d         = sr_q >> 1;
          sr_d[dr_msb] = tdi_s2_q;
        end
        default: ;
      endcase

      if (tap_next == UPD_IR) ir_d = sr_q[4:0];

      if (tap_next == UPD_DR) begin
        if (ir_q == IR_DTMCS) begin
          if (sr_q[16] || sr_q[17]) sticky_d = 2'd0;
          if (sr_q[17]) busy_d = 1'b0;
        end else if (ir_q == IR_DMI) begin
          if (sr_q[1:0] == 2'd3) begin
            sticky_d = 2'd2;
          end else if (sr_q[1:0] == OP_READ || sr_q[1:0] == OP_WRITE) begin
            if (busy_q) begin
              sticky_d = 2'd3;
            end else begin
              dmi_addr_d  = sr_q[40:34];
              dmi_data_d  = sr_q[33:2];
              dmi_op_d    = sr_q[1:0];
              dmi_start_d = 1'b1;
              busy_d      = 1'b1;
            end
          end
        end
      end
    end

    if (fall_q) tdo_d = (state_q == SH_DR || state_q == SH_IR) ? sr_q[0] : 1'b0;

    if (state_q == TLR) ir_d = IR_IDCODE;
  end

  // All state, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_s1_q    <= 1'b0;
      tck_s2_q    <= 1'b0;
      tck_prev_q  <= 1'b0;
      tms_s1_q    <= 1'b0;
      tms_s2_q    <= 1'b0;
      tdi_s1_q    <= 1'b0;
      tdi_s2_q    <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= TLR;
      ir_q        <= IR_IDCODE;
      sr_q        <= 41'd0;
      tdo_q       <= 1'b0;
      busy_q      <= 1'b0;
      sticky_q    <= 2'd0;
      result_q    <= 32'd0;
      dmi_start_q <= 1'b0;
      dmi_op_q    <= 2'd0;
      dmi_data_q  <= 32'd0;
      dmi_addr_q  <= 7'd0;
    end else begin
      tck_s1_q    <= tck_s1_d;
      tck_s2_q    <= tck_s2_d;
      tck_prev_q  <= tck_prev_d;
      tms_s1_q    <= tms_s1_d;
      tms_s2_q    <= tms_s2_d;
      tdi_s1_q    <= tdi_s1_d;
      tdi_s2_q    <= tdi_s2_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      ir_q        <= ir_d;
      sr_q        <= sr_d;
      tdo_q       <= tdo_d;
      busy_q      <= busy_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      dmi_start_q <= dmi_start_d;
      dmi_op_q    <= dmi_op_d;
      dmi_data_q  <= dmi_data_d;
      dmi_addr_q  <= dmi_addr_d;
    end
  end

  assign tdo         = tdo_q;
  assign dmi_start   = dmi_start_q;
  assign dmi_op      = dmi_op_q;
  assign dmi_data_o  = dmi_data_q;
  assign dmi_address = dmi_addr_q;

endmodule

// File: doc/dtm_jtag.md
DTM_JTAG -- requirements
Module: dtm_jtag

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1BEEF001, returned by the IDCODE data register; bit 0 SHALL be 1.
REQ-002 SHALL have port clk, input, 1: the single system clock, shared with the debug module.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port tck, input, 1: JTAG clock, asynchronous, sampled by clk.
REQ-005 SHALL have port tms, input, 1: JTAG mode select, asynchronous.
REQ-006 SHALL have port tdi, input, 1: JTAG serial data in, asynchronous.
REQ-007 SHALL have port tdo, output, 1: JTAG serial data out.
REQ-008 SHALL have port dmi_start, output, 1: one-clk request pulse to the debug module.
REQ-009 SHALL have port dmi_finish, input, 1: one-clk completion pulse from the debug module.
REQ-010 SHALL have port dmi_op, output, 2: 1 = read, 2 = write.
REQ-011 SHALL have port dmi_data_o, output, [33:2]: write data.
REQ-012 SHALL have port dmi_data_i, input, [33:2]: read data, valid in the dmi_finish cycle.
REQ-013 SHALL have port dmi_address, output, [40:34]: DM register address.

Function
REQ-014 SHALL pass tck, tms and tdi each through a 2-flop synchronizer; a tck rise or fall SHALL be detected from the synced tck versus its previous value.
REQ-015 SHALL support tck high and low phases of at least 3 clk each; shorter phases are unsupported.
REQ-016 SHALL update a 16-state IEEE 1149.1 TAP FSM (TLR, RTI, Select/Capture/Shift/Exit1/Pause/Exit2/Update for both DR and IR) using synced tms in the cycle after a detected rise.
REQ-017 SHALL implement a 5-bit IR: 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI; all other codes SHALL select the 1-bit BYPASS register.
REQ-018 SHALL load IR with 0x01 in TLR.
REQ-019 SHALL load the IR shift register with 5'b00001 in Capture-IR.
REQ-020 SHALL shift all registers LSB first: tdi enters at the MSB, tdo is taken from bit 0.
REQ-021 SHALL make DMI scans 41 bits: {address[40:34], data[33:2], op[1:0]}.
REQ-022 SHALL make DTMCS read 32'h00001071, i.e. version=1 [3:0], abits=7 [9:4], idle=1 [14:12], with dmistat at [11:10].
REQ-023 SHALL update tdo only on a detected tck fall: shift-register bit 0 in Shift-DR/Shift-IR, otherwise 0.
REQ-024 SHALL, in Capture-DR with DMI selected, load {last address, result data, status}; status = 3 if busy, else the sticky error.
REQ-025 SHALL, on entering Update-DR with DMI selected, op ∈ {1,2} and not busy, latch address, data and op onto the dmi_* outputs, pulse dmi_start for exactly one clk in the next cycle, and set busy.
REQ-026 SHALL treat op 0 (nop) in Update-DR as no request.
REQ-027 SHALL treat op 3 in Update-DR as no request and set sticky error 2.
REQ-028 SHALL, on an Update-DR DMI request while busy, drop the request, issue no dmi_start, and set sticky error 3.
REQ-029 SHALL, in a dmi_finish cycle, capture result <= dmi_data_i for read ops (keep previous result for writes) and clear busy; a new dmi_start is allowed from the next clk.
REQ-030 SHALL ignore dmi_finish while not busy.
REQ-031 SHALL, on Update-DR of DTMCS with bit 16 (dmireset) set, clear the sticky error.
REQ-032 SHALL, on Update-DR of DTMCS with bit 17 (dmihardreset) set, clear both the sticky error and busy; a later dmi_finish for the aborted op SHALL be ignored.
REQ-033 SHALL keep dmi_address, dmi_data_o and dmi_op stable from dmi_start until busy clears.
REQ-034 SHALL, on a tck rise and a dmi_finish in the same clk, perform both actions independently.

Reset
REQ-035 SHALL, while rst_n is low, asynchronously set: TAP=TLR, IR=0x01, tdo=0, dmi_start=0, busy=0, sticky=0, result=0, dmi_op=0, dmi_data_o=0, dmi_address=0, and all synchronizers to 0.
REQ-036 SHALL, on reset assertion mid-request, abandon the request without issuing a dmi_start pulse.

Verification
REQ-037 SHALL be checked by: reset, 5 TCKs with TMS=1, enter Shift-DR -> 32 shifted tdo bits equal 32'h1BEEF001.
REQ-038 SHALL be checked by: IR=0x10, scan DR -> 32'h00001071 with dmistat=0.
REQ-039 SHALL be checked by: DMI scan {0x10, 0x00000001, op 2} -> single dmi_start with dmi_address=0x10, dmi_data_o=1, dmi_op=2; model returns dmi_finish 2 clk later; next capture status=0.
REQ-040 SHALL be checked by: DMI read of 0x11, model returns 0x00000C82 -> next scan shifts out data 0xC82, status 0, address 0x11.
REQ-041 SHALL be checked by: model withholds dmi_finish, second DMI update issued -> no second dmi_start, capture status 3, DTMCS dmistat=3; DTMCS write with bit 16 after finish -> status 0.
REQ-042 SHALL be checked by: rst_n pulsed low while busy with tck toggling -> all outputs 0, IR reads IDCODE, no spurious dmi_start after release.
